// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver and its front-end: opcodes, bus widths,
// and the driver state encoding.
package alu_pkg;

    localparam int unsigned ALU_BUS_W = 8;
    localparam int unsigned OPND_W    = 4;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned CNT_W     = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_NAND = 4'd7;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd8;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd9;
    localparam logic [OP_W-1:0] OP_MOD  = 4'd10;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd11;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd12;
    localparam logic [OP_W-1:0] OP_MAX  = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Divide and modulo are the only operations whose result is undefined for y == 0.
    function automatic logic op_needs_nonzero_y(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_req_check.sv
// Combinational request legality check: flags divide/mod by zero and opcodes
// beyond the ALU's range. Shared with the command front-end for early rejection.
module alu_req_check
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [OPND_W-1:0] i_y,
    output logic              o_err
);

    logic w_div_zero;
    logic w_bad_op;

    always_comb begin
        w_div_zero = op_needs_nonzero_y(i_op) && (i_y == '0);
        w_bad_op   = (i_op > OP_MAX);
        o_err      = w_div_zero || w_bad_op;
    end

endmodule

// File: rtl/alu_driver.sv
// Sequential initiator for the 4-bit ALU: latches one request onto registered
// ALU buses, waits SETTLE_CYCLES, then returns the sampled result with an error flag.
module alu_driver
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_W-1:0]      req_op,
    input  logic [OPND_W-1:0]    req_x,
    input  logic [OPND_W-1:0]    req_y,
    output logic [ALU_BUS_W-1:0] alu_operands,
    output logic [ALU_BUS_W-1:0] alu_opcode,
    input  logic [ALU_BUS_W-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_BUS_W-1:0] rsp_data,
    output logic [OP_W-1:0]      rsp_op,
    output logic                 rsp_err,
    output logic [7:0]           txn_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_driver: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [OPND_W-1:0]     r_x;
    logic [OPND_W-1:0]     r_y;
    logic [OP_W-1:0]       r_op;
    logic                  r_rsp_valid;
    logic [ALU_BUS_W-1:0]  r_rsp_data;
    logic [OP_W-1:0]       r_rsp_op;
    logic                  r_rsp_err;
    logic [7:0]            r_txn_count;
    logic                  w_err;

    // Legality is judged on the registered bus values, i.e. what the ALU actually sees.
    alu_req_check u_req_check (
        .i_op  (r_op),
        .i_y   (r_y),
        .o_err (w_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_op        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_op    <= '0;
            r_rsp_err   <= 1'b0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_x      <= req_x;
                        r_y      <= req_y;
                        r_op     <= req_op;
                        r_rsp_op <= req_op;
                        r_cnt    <= SETTLE_LOAD;
                        r_state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= w_err ? '0 : alu_result;
                        r_rsp_err   <= w_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_txn_count <= r_txn_count + 8'd1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready    = (r_state == IDLE);
        alu_operands = {r_y, r_x};
        alu_opcode   = {{(ALU_BUS_W - OP_W){1'b0}}, r_op};
        rsp_valid    = r_rsp_valid;
        rsp_data     = r_rsp_data;
        rsp_op       = r_rsp_op;
        rsp_err      = r_rsp_err;
        txn_count    = r_txn_count;
    end

endmodule
